// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the 2-way, 8-set L1 cache controller.
// State encodings are kept as fixed constants so legacy tools see the same values.
package cache_pkg;

  localparam int unsigned OFFSET_W = 5;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned TAG_W    = 32 - IDX_W - OFFSET_W;

  localparam logic [1:0] ST_CHECK     = 2'd0;
  localparam logic [1:0] ST_WRITEBACK = 2'd1;
  localparam logic [1:0] ST_FILL      = 2'd2;

  typedef enum logic [1:0] {
    CHECK     = ST_CHECK,
    WRITEBACK = ST_WRITEBACK,
    FILL      = ST_FILL
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
    return addr[31 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
    return addr[OFFSET_W +: IDX_W];
  endfunction

endpackage

// File: rtl/cache_ctrl_fsm.sv
// Control FSM for the 2-way write-back/write-allocate L1 cache: hit detection, LRU update,
// writeback and fill bursts. Define CACHE_CTRL_PERF_EN to add hit/miss/writeback counters.
module cache_ctrl_fsm #(
  parameter int unsigned TAG_W    = 24,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned OFFSET_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [31:0]          mem_address,
  output logic                 mem_resp,
  input  logic [2*TAG_W-1:0]   tag_out,
  input  logic [1:0]           valid_out,
  input  logic [1:0]           dirty_out,
  input  logic                 lru_out,
  output logic [1:0]           tag_load,
  output logic [1:0]           valid_load,
  output logic [1:0]           dirty_load,
  output logic [1:0]           data_load,
  output logic                 dirty_in,
  output logic                 lru_load,
  output logic                 lru_in,
  output logic [IDX_W-1:0]     set_idx,
  output logic                 way_sel,
  output logic                 data_src_sel,
  output logic                 pmem_addr_sel,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp
`ifdef CACHE_CTRL_PERF_EN
  ,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt,
  output logic [31:0]          wb_cnt
`endif
);

  import cache_pkg::*;

  state_t           r_state;
  state_t           w_next;
  logic             r_victim;
  logic [TAG_W-1:0] w_req_tag;
  logic             w_req;
  logic             w_hit0;
  logic             w_hit1;
  logic             w_hit;
  logic             w_hit_way;
  logic             w_victim_dirty;
  logic             w_unused_off;

  assign w_req          = mem_read | mem_write;
  assign w_req_tag      = addr_tag(mem_address);
  assign set_idx        = addr_idx(mem_address);
  assign w_unused_off   = ^mem_address[OFFSET_W-1:0];
  assign w_hit0         = valid_out[0] & (tag_out[0 +: TAG_W] == w_req_tag);
  assign w_hit1         = valid_out[1] & (tag_out[TAG_W +: TAG_W] == w_req_tag);
  assign w_hit          = w_hit0 | w_hit1;
  // A simultaneous double hit is illegal; way0 takes priority.
  assign w_hit_way      = ~w_hit0;
  assign w_victim_dirty = valid_out[lru_out] & dirty_out[lru_out];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= CHECK;
      r_victim <= 1'b0;
    end else begin
      r_state <= w_next;
      // Victim is frozen for the whole miss so a mid-miss LRU change cannot redirect the fill.
      if (r_state == CHECK && w_req && !w_hit) begin
        r_victim <= lru_out;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    mem_resp      = 1'b0;
    tag_load      = '0;
    valid_load    = '0;
    dirty_load    = '0;
    data_load     = '0;
    dirty_in      = 1'b0;
    lru_load      = 1'b0;
    lru_in        = 1'b0;
    way_sel       = 1'b0;
    data_src_sel  = 1'b0;
    pmem_addr_sel = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    // Outputs are held quiet while rst is high so an abandoned burst cannot strobe the arrays.
    if (!rst) begin
      unique case (r_state)
        CHECK: begin
          if (w_req) begin
            if (w_hit) begin
              mem_resp = 1'b1;
              lru_load = 1'b1;
              lru_in   = ~w_hit_way;
              way_sel  = w_hit_way;
              if (mem_write) begin
                data_load[w_hit_way]  = 1'b1;
                dirty_load[w_hit_way] = 1'b1;
                dirty_in              = 1'b1;
              end
            end else begin
              w_next = w_victim_dirty ? WRITEBACK : FILL;
            end
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          way_sel       = r_victim;
          if (pmem_resp) begin
            w_next = FILL;
          end
        end
        FILL: begin
          pmem_read = 1'b1;
          way_sel   = r_victim;
          if (pmem_resp) begin
            data_load[r_victim]  = 1'b1;
            tag_load[r_victim]   = 1'b1;
            valid_load[r_victim] = 1'b1;
            dirty_load[r_victim] = 1'b1;
            data_src_sel         = 1'b1;
            w_next               = CHECK;
          end
        end
        default: w_next = CHECK;
      endcase
    end
  end

`ifdef CACHE_CTRL_PERF_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;
  logic [31:0] r_wb_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      if (r_state == CHECK && w_req && w_hit) r_hit_cnt <= r_hit_cnt + 32'd1;
      if (r_state == CHECK && w_req && !w_hit) r_miss_cnt <= r_miss_cnt + 32'd1;
      if (r_state == WRITEBACK && pmem_resp) r_wb_cnt <= r_wb_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
  assign wb_cnt   = r_wb_cnt;
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed bench for cache_ctrl_fsm; array contents are modelled by hand-updated tb variables.
// Build with CACHE_CTRL_PERF_EN to also check the performance counters.
module tb_cache_ctrl_fsm;
  import cache_pkg::*;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic        mem_resp;
  logic [47:0] tag_out;
  logic [1:0]  valid_out;
  logic [1:0]  dirty_out;
  logic        lru_out;
  logic [1:0]  tag_load;
  logic [1:0]  valid_load;
  logic [1:0]  dirty_load;
  logic [1:0]  data_load;
  logic        dirty_in;
  logic        lru_load;
  logic        lru_in;
  logic [2:0]  set_idx;
  logic        way_sel;
  logic        data_src_sel;
  logic        pmem_addr_sel;
  logic        pmem_read;
  logic        pmem_write;
  logic        pmem_resp;
`ifdef CACHE_CTRL_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  logic [31:0] wb_cnt;
`endif

  logic [23:0] m_tag0;
  logic [23:0] m_tag1;
  int          n_checks;
  int          n_fail;

  assign tag_out = {m_tag1, m_tag0};

  cache_ctrl_fsm #(.TAG_W(24), .IDX_W(3), .OFFSET_W(5)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_resp(mem_resp),
    .tag_out(tag_out), .valid_out(valid_out), .dirty_out(dirty_out), .lru_out(lru_out),
    .tag_load(tag_load), .valid_load(valid_load), .dirty_load(dirty_load),
    .data_load(data_load), .dirty_in(dirty_in), .lru_load(lru_load), .lru_in(lru_in),
    .set_idx(set_idx), .way_sel(way_sel), .data_src_sel(data_src_sel),
    .pmem_addr_sel(pmem_addr_sel), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp)
`ifdef CACHE_CTRL_PERF_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [16:0] ctl_outs();
    return {mem_resp, tag_load, valid_load, dirty_load, data_load, dirty_in, lru_load,
            lru_in, way_sel, data_src_sel, pmem_addr_sel, pmem_read, pmem_write};
  endfunction

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = 32'h0;
    pmem_resp   = 1'b0;
    valid_out   = 2'b00;
    dirty_out   = 2'b00;
    lru_out     = 1'b0;
    m_tag0      = 24'h0;
    m_tag1      = 24'h0;

    // 1: reset, then idle
    next_cycle();
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      settle();
      chk("idle_outs", {15'b0, ctl_outs()}, 32'h0);
    end
    chk("idle_state", {30'b0, dut.r_state}, {30'b0, ST_CHECK});
    chk("idle_set_idx", {29'b0, set_idx}, 32'h0);
`ifdef CACHE_CTRL_PERF_EN
    chk("perf_reset_hit", hit_cnt, 32'd0);
    chk("perf_reset_miss", miss_cnt, 32'd0);
    chk("perf_reset_wb", wb_cnt, 32'd0);
`endif

    // 2: cold read of 0x1020 (tag 0x10, set 1), both ways invalid, lru picks way0
    next_cycle();
    mem_read    = 1'b1;
    mem_address = 32'h0000_1020;
    settle();
    chk("cold_set_idx", {29'b0, set_idx}, 32'd1);
    chk("cold_miss_resp", {31'b0, mem_resp}, 32'd0);
    chk("cold_miss_pmem_rd", {31'b0, pmem_read}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      settle();
      chk("fill_wait_pmem_rd", {31'b0, pmem_read}, 32'd1);
      chk("fill_wait_loads", {24'b0, valid_load, tag_load, data_load, dirty_load}, 32'h0);
    end
    next_cycle();
    pmem_resp = 1'b1;
    settle();
    chk("fill0_valid_load", {30'b0, valid_load}, 32'b01);
    chk("fill0_tag_data_dirty", {26'b0, tag_load, data_load, dirty_load}, 32'b01_01_01);
    chk("fill0_dirty_in_src", {30'b0, dirty_in, data_src_sel}, 32'b01);
    chk("fill0_addr_sel_resp", {30'b0, pmem_addr_sel, mem_resp}, 32'b00);
    next_cycle();
    pmem_resp = 1'b0;
    m_tag0    = 24'h000010;
    valid_out = 2'b01;
    settle();
    chk("fill0_hit_resp", {31'b0, mem_resp}, 32'd1);
    chk("fill0_hit_lru", {30'b0, lru_load, lru_in}, 32'b11);
    chk("fill0_hit_pmem", {30'b0, pmem_read, pmem_write}, 32'b00);

    // 3: write hit on 0x1024 after two idle cycles
    next_cycle();
    mem_read = 1'b0;
    lru_out  = 1'b1;
    next_cycle();
    next_cycle();
    mem_write   = 1'b1;
    mem_address = 32'h0000_1024;
    settle();
    chk("wr_hit_resp", {31'b0, mem_resp}, 32'd1);
    chk("wr_hit_data_load", {30'b0, data_load}, 32'b01);
    chk("wr_hit_dirty", {29'b0, dirty_load, dirty_in}, 32'b011);
    chk("wr_hit_src_lru", {29'b0, data_src_sel, lru_load, lru_in}, 32'b011);

    // 4a: read 0x2020 fills invalid way1 (lru=1)
    next_cycle();
    mem_write   = 1'b0;
    dirty_out   = 2'b01;
    mem_read    = 1'b1;
    mem_address = 32'h0000_2020;
    settle();
    chk("rd2_miss_outs", {15'b0, ctl_outs()}, 32'h0);
    next_cycle();
    pmem_resp = 1'b1;
    settle();
    chk("fill1_loads", {24'b0, valid_load, tag_load, data_load, dirty_load}, 32'b10_10_10_10);
    chk("fill1_rd_wr", {30'b0, pmem_read, pmem_write}, 32'b10);
    next_cycle();
    pmem_resp = 1'b0;
    m_tag1    = 24'h000020;
    valid_out = 2'b11;
    settle();
    chk("rd2_hit_resp_way", {30'b0, mem_resp, way_sel}, 32'b11);
    chk("rd2_hit_lru", {30'b0, lru_load, lru_in}, 32'b10);

    // 4b: read 0x3020 evicts dirty way0 via WRITEBACK
    next_cycle();
    mem_read = 1'b0;
    lru_out  = 1'b0;
    next_cycle();
    mem_read    = 1'b1;
    mem_address = 32'h0000_3020;
    settle();
    chk("rd3_miss_outs", {15'b0, ctl_outs()}, 32'h0);
    next_cycle();
    lru_out = 1'b1;
    settle();
    chk("wb_pmem_write", {30'b0, pmem_write, pmem_read}, 32'b10);
    chk("wb_addr_sel_way", {30'b0, pmem_addr_sel, way_sel}, 32'b10);
    next_cycle();
    pmem_resp = 1'b1;
    settle();
    chk("wb_resp_no_strobes", {24'b0, valid_load, tag_load, data_load, dirty_load}, 32'h0);
    next_cycle();
    pmem_resp = 1'b0;
    settle();
    chk("wb_then_fill", {29'b0, pmem_read, pmem_write, pmem_addr_sel}, 32'b100);
    next_cycle();
    pmem_resp = 1'b1;
    settle();
    chk("fill_latched_victim", {28'b0, data_load, valid_load}, 32'b01_01);
    chk("fill_dirty_clear", {30'b0, dirty_in, data_src_sel}, 32'b01);
    next_cycle();
    pmem_resp = 1'b0;
    m_tag0    = 24'h000030;
    dirty_out = 2'b00;
    lru_out   = 1'b0;
    settle();
    chk("rd3_hit_resp", {31'b0, mem_resp}, 32'd1);
    chk("rd3_hit_lru_in", {31'b0, lru_in}, 32'd1);
`ifdef CACHE_CTRL_PERF_EN
    next_cycle();
    mem_read = 1'b0;
    settle();
    chk("perf_hit_cnt", hit_cnt, 32'd4);
    chk("perf_miss_cnt", miss_cnt, 32'd3);
    chk("perf_wb_cnt", wb_cnt, 32'd1);
`else
    next_cycle();
    mem_read = 1'b0;
`endif

    // 5: reset during FILL, with pmem_resp arriving in the reset cycle
    lru_out = 1'b1;
    next_cycle();
    mem_read    = 1'b1;
    mem_address = 32'h0000_4020;
    next_cycle();
    settle();
    chk("rst_pre_pmem_rd", {31'b0, pmem_read}, 32'd1);
    next_cycle();
    rst       = 1'b1;
    mem_read  = 1'b0;
    pmem_resp = 1'b1;
    settle();
    chk("rst_no_strobes", {24'b0, valid_load, tag_load, data_load, dirty_load}, 32'h0);
    next_cycle();
    rst       = 1'b0;
    pmem_resp = 1'b0;
    settle();
    chk("rst_post_outs", {15'b0, ctl_outs()}, 32'h0);
    chk("rst_post_state", {30'b0, dut.r_state}, {30'b0, ST_CHECK});

    // 6: spurious pmem_resp in CHECK with no request
    next_cycle();
    pmem_resp = 1'b1;
    settle();
    chk("spur_outs", {15'b0, ctl_outs()}, 32'h0);
    next_cycle();
    pmem_resp = 1'b0;
    settle();
    chk("spur_state", {30'b0, dut.r_state}, {30'b0, ST_CHECK});
    chk("spur_resp", {31'b0, mem_resp}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
